// File: rtl/sched_pkg.sv
// rtl/sched_pkg.sv - state encoding and shared constants for source_tx_scheduler
package sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        BUSY    = 2'd2,
        RECOVER = 2'd3
    } sched_state_t;

    localparam int CNT_W              = 16;
    localparam int DEF_TIMEOUT_CYCLES = 4096;

endpackage

// File: rtl/source_tx_scheduler_if.sv
// rtl/source_tx_scheduler_if.sv - grant/acknowledge handshake between scheduler and Slave FIFO writer
interface source_tx_scheduler_if #(
    parameter int NUM_SOURCES = 4,
    parameter int SRC_W       = $clog2(NUM_SOURCES)
);
    logic                   GRANT_VALID;
    logic [SRC_W-1:0]       GRANT_SRC;
    logic [7:0]             GRANT_LEN;
    logic [NUM_SOURCES-1:0] GRANT_ONEHOT;
    logic                   GRANT_ACK;
    logic [NUM_SOURCES-1:0] MSG_SENT;

    modport master (
        output GRANT_VALID, GRANT_SRC, GRANT_LEN, GRANT_ONEHOT,
        input  GRANT_ACK, MSG_SENT
    );

    modport slave (
        input  GRANT_VALID, GRANT_SRC, GRANT_LEN, GRANT_ONEHOT,
        output GRANT_ACK, MSG_SENT
    );
endinterface

// File: rtl/source_tx_scheduler_rr_pick.sv
// rtl/source_tx_scheduler_rr_pick.sv - rotating priority encoder: first request at or after ptr
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);
    int         pos;
    logic [W-1:0] cand;

    // Scan from the far end backwards so the closest request to ptr is written last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        cand  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = int'(ptr) + k;
            if (pos >= N) pos = pos - N;
            cand = pos[W-1:0];
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end
endmodule

// File: rtl/source_tx_scheduler.sv
// rtl/source_tx_scheduler.sv - weighted round-robin grant scheduler for the Slave FIFO write path
// Optional per-source grant counters: SOURCE_TX_SCHED_STATS_EN.
`ifndef NUM_SOURCES
`define NUM_SOURCES 4
`endif

module source_tx_scheduler
    import sched_pkg::*;
#(
    parameter int NUM_SOURCES    = `NUM_SOURCES,
    parameter int SRC_W          = $clog2(NUM_SOURCES),
    parameter int WEIGHT_W       = 4,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [NUM_SOURCES-1:0]          GOT_FULL_MSG,
    input  logic [NUM_SOURCES*8-1:0]        MSG_LEN_BUS,
    input  logic [NUM_SOURCES*WEIGHT_W-1:0] WEIGHT_BUS,
    input  logic [NUM_SOURCES-1:0]          SRC_ENABLE,
    source_tx_scheduler_if.master           gnt,
    output logic                            TIMEOUT_ERR,
    output logic [NUM_SOURCES*CNT_W-1:0]    GRANT_CNT_BUS,
    output logic [1:0]                      state_monitor
);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    sched_state_t           state;
    logic [SRC_W-1:0]       rr_ptr;
    logic [SRC_W-1:0]       grant_src;
    logic [WEIGHT_W-1:0]    quota_left;
    logic [TMO_W-1:0]       tmo_cnt;
    logic                   grant_valid;
    logic [7:0]             grant_len;
    logic [NUM_SOURCES-1:0] grant_onehot;

    logic [NUM_SOURCES-1:0] eligible;
    logic                   pick_found;
    logic [SRC_W-1:0]       pick_idx;
    logic [WEIGHT_W-1:0]    pick_weight;
    logic                   sent_granted;
    logic                   tmo_hit;
    logic [SRC_W-1:0]       next_ptr;

    assign eligible = GOT_FULL_MSG & SRC_ENABLE;

    rr_pick #(.N(NUM_SOURCES), .W(SRC_W)) u_pick (
        .req   (eligible),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign pick_weight  = WEIGHT_BUS[pick_idx*WEIGHT_W +: WEIGHT_W];
    assign sent_granted = gnt.MSG_SENT[grant_src];
    assign tmo_hit      = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign next_ptr     = (grant_src == SRC_W'(NUM_SOURCES - 1)) ? '0 : grant_src + 1'b1;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            quota_left   <= '0;
            tmo_cnt      <= '0;
            grant_valid  <= 1'b0;
            grant_src    <= '0;
            grant_len    <= '0;
            grant_onehot <= '0;
            TIMEOUT_ERR  <= 1'b0;
        end else begin
            TIMEOUT_ERR <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state        <= GRANT;
                        grant_valid  <= 1'b1;
                        grant_src    <= pick_idx;
                        grant_len    <= MSG_LEN_BUS[pick_idx*8 +: 8];
                        grant_onehot <= NUM_SOURCES'(1) << pick_idx;
                        tmo_cnt      <= '0;
                        // quota_left == 0 marks an exhausted quota, so a repeat winner reloads too
                        if (pick_idx != grant_src || quota_left == '0)
                            quota_left <= (pick_weight == '0) ? WEIGHT_W'(1) : pick_weight;
                    end
                end
                GRANT, BUSY: begin
                    if (sent_granted && (state == BUSY || gnt.GRANT_ACK)) begin
                        state        <= IDLE;
                        grant_valid  <= 1'b0;
                        grant_onehot <= '0;
                        if (quota_left > WEIGHT_W'(1)) begin
                            quota_left <= quota_left - 1'b1;
                        end else begin
                            quota_left <= '0;
                            rr_ptr     <= next_ptr;
                        end
                    end else if (tmo_hit) begin
                        state        <= RECOVER;
                        grant_valid  <= 1'b0;
                        grant_onehot <= '0;
                        TIMEOUT_ERR  <= 1'b1;
                        quota_left   <= '0;
                        rr_ptr       <= next_ptr;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        if (state == GRANT && gnt.GRANT_ACK) begin
                            state       <= BUSY;
                            grant_valid <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign gnt.GRANT_VALID  = grant_valid;
    assign gnt.GRANT_SRC    = grant_src;
    assign gnt.GRANT_LEN    = grant_len;
    assign gnt.GRANT_ONEHOT = grant_onehot;
    assign state_monitor    = state;

`ifdef SOURCE_TX_SCHED_STATS_EN
    logic [CNT_W-1:0] grant_cnt [NUM_SOURCES];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < NUM_SOURCES; i++) grant_cnt[i] <= '0;
        end else if (state == GRANT && gnt.GRANT_ACK && grant_cnt[grant_src] != '1) begin
            grant_cnt[grant_src] <= grant_cnt[grant_src] + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_cnt
        assign GRANT_CNT_BUS[g*CNT_W +: CNT_W] = grant_cnt[g];
    end
`else
    assign GRANT_CNT_BUS = '0;
`endif

endmodule
